pipe_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and NOP injection on bubbles. It is the generalised successor to the fixed fetch/decode flop stage and sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls and flushes are handled inside the stage instead of being wired around bare flops. The payload is an opaque bus, e.g. {pc_next, instruction}.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_entry.sv | 37 +++
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [OCC_W-1:0] state_occ(state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    unique case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage: payload register plus valid bit, cleared to NOP_VALUE.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Drop only clears the valid bit; data holds to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (drop) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and NOP output on bubbles.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'({16'h0000, NOP_INSTR})
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [OCC_W-1:0] occ_q;

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_load, main_drop, skid_load, skid_drop;
  logic [WIDTH-1:0] main_din;
  logic             accept, consume;

  // A payload offered during flush is lost even if in_ready is high.
  assign accept  = in_valid & in_ready_q & ~flush;
  assign consume = main_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    main_din  = in_data;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (consume) begin
          main_drop = 1'b1;
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          main_load = 1'b1;
          main_din  = skid_data;
          skid_drop = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Handshake/occupancy outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      occ_q      <= state_occ(state_d);
    end
  end

  pipe_entry #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (main_load),
    .drop  (main_drop),
    .din   (main_din),
    .valid (main_valid),
    .data  (main_data)
  );

  pipe_entry #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (skid_load),
    .drop  (skid_drop),
    .din   (in_data),
    .valid (skid_valid),
    .data  (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : NOP_VALUE;

endmodule
